// File: rtl/axi4_ram_arbiter.sv
// Two-requester arbiter in front of a single AXI4-style RAM port: m0 fetches (read-only),
// m1 reads or writes. One transaction in flight; grant, latch, run AR/R or AW/W/B, respond.
module axi4_ram_arbiter #(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 64,
    parameter  int ARB_MODE = 0,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // fetch requester
    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    // data requester
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [STRB_W-1:0] i_m1_wstrb,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_bdone,
    // RAM port
    output logic [ADDR_W-1:0] o_ram_araddr,
    output logic              o_ram_arvalid,
    input  logic              i_ram_arready,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [ADDR_W-1:0] o_ram_awaddr,
    output logic              o_ram_awvalid,
    input  logic              i_ram_awready,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic [STRB_W-1:0] o_ram_wstrb,
    output logic              o_ram_wvalid,
    input  logic              i_ram_wready,
    input  logic              i_ram_bvalid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic              r_run;
    logic              r_rr_m1;
    logic              r_owner_m1;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_arvalid;
    logic              r_awvalid;
    logic              r_wvalid;

    logic              w_idle;
    logic              w_grant;
    logic              w_pick_m1;
    logic              w_gnt_m0;
    logic              w_gnt_m1;
    logic              w_grant_write;
    logic              w_ar_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_done;
    logic              w_w_done;
    logic [1:0]        w_rvalid;
    logic [DATA_W-1:0] w_rdata [2];

    // r_run keeps grants off while reset is held and for the release cycle,
    // so no gnt pulse can escape while the flops are still being cleared.
    assign w_idle        = (r_state == S_IDLE);
    assign w_grant       = w_idle && r_run && (i_m0_req || i_m1_req);
    assign w_pick_m1     = i_m1_req && ((ARB_MODE == 1) || !i_m0_req || r_rr_m1);
    assign w_gnt_m1      = w_grant && w_pick_m1;
    assign w_gnt_m0      = w_grant && !w_pick_m1;
    assign w_grant_write = w_gnt_m1 && i_m1_we;

    assign w_ar_hs   = r_arvalid && i_ram_arready;
    assign w_aw_hs   = r_awvalid && i_ram_awready;
    assign w_w_hs    = r_wvalid && i_ram_wready;
    assign w_aw_done = !r_awvalid || i_ram_awready;
    assign w_w_done  = !r_wvalid || i_ram_wready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_next = w_grant_write ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                w_state_next = S_IDLE;
            end
            S_WR_REQ: begin
                if (w_aw_done && w_w_done) begin
                    w_state_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (i_ram_bvalid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_rr_m1    <= 1'b1;
            r_owner_m1 <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_arvalid  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            if (w_grant) begin
                r_owner_m1 <= w_gnt_m1;
                r_rr_m1    <= !w_gnt_m1;
                r_addr     <= w_gnt_m1 ? i_m1_addr : i_m0_addr;
                if (w_gnt_m1) begin
                    r_wdata <= i_m1_wdata;
                    r_wstrb <= i_m1_wstrb;
                end
            end
            if (w_grant && !w_grant_write) begin
                r_arvalid <= 1'b1;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end
            // AW and W retire independently; WR_REQ exits once both have.
            if (w_grant_write) begin
                r_awvalid <= 1'b1;
            end else if (w_aw_hs) begin
                r_awvalid <= 1'b0;
            end
            if (w_grant_write) begin
                r_wvalid <= 1'b1;
            end else if (w_w_hs) begin
                r_wvalid <= 1'b0;
            end
        end
    end

    // Per-requester read return: live pass-through when owning RD_DATA, else last value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] r_rdata_hold;

            assign w_rvalid[gi] = (r_state == S_RD_DATA) &&
                                  ((gi == 1) ? r_owner_m1 : !r_owner_m1);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rdata_hold <= '0;
                end else if (w_rvalid[gi]) begin
                    r_rdata_hold <= i_ram_rdata;
                end
            end

            assign w_rdata[gi] = w_rvalid[gi] ? i_ram_rdata : r_rdata_hold;
        end
    endgenerate

    assign o_m0_gnt      = w_gnt_m0;
    assign o_m1_gnt      = w_gnt_m1;
    assign o_m0_rvalid   = w_rvalid[0];
    assign o_m1_rvalid   = w_rvalid[1];
    assign o_m0_rdata    = w_rdata[0];
    assign o_m1_rdata    = w_rdata[1];
    assign o_m1_bdone    = (r_state == S_WR_RESP) && i_ram_bvalid;

    assign o_ram_araddr  = r_addr;
    assign o_ram_arvalid = r_arvalid;
    assign o_ram_awaddr  = r_addr;
    assign o_ram_awvalid = r_awvalid;
    assign o_ram_wdata   = r_wdata;
    assign o_ram_wstrb   = r_wstrb;
    assign o_ram_wvalid  = r_wvalid;

    a_one_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_m0_gnt && o_m1_gnt));
    a_ar_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_arvalid && !i_ram_arready) |=> (r_arvalid && $stable(o_ram_araddr)));
    a_aw_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_awvalid && !i_ram_awready) |=> (r_awvalid && $stable(o_ram_awaddr)));

endmodule

// File: tb/tb_axi4_ram_arbiter.sv
// Directed bench for axi4_ram_arbiter: stimulus pushes expected events into a queue,
// a negedge monitor pops and compares each gnt/rvalid/bdone pulse the DUT presents.
module tb_axi4_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    localparam int EV_G0 = 0;
    localparam int EV_G1 = 1;
    localparam int EV_R0 = 2;
    localparam int EV_R1 = 3;
    localparam int EV_B1 = 4;

    typedef struct {
        int          kind;
        logic [63:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          m0_req, m1_req, m1_we;
    logic          fp_m0_req, fp_m1_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [SW-1:0] m1_wstrb;
    logic          ram_arready, ram_awready, ram_wready, ram_bvalid;
    logic [DW-1:0] ram_rdata;

    logic          o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_m1_bdone;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata;
    logic [AW-1:0] o_ram_araddr, o_ram_awaddr;
    logic          o_ram_arvalid, o_ram_awvalid, o_ram_wvalid;
    logic [DW-1:0] o_ram_wdata;
    logic [SW-1:0] o_ram_wstrb;

    logic          fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_m1_bdone;
    logic [DW-1:0] fp_m0_rdata, fp_m1_rdata;
    logic [AW-1:0] fp_araddr, fp_awaddr;
    logic          fp_arvalid, fp_awvalid, fp_wvalid;
    logic [DW-1:0] fp_wdata;
    logic [SW-1:0] fp_wstrb;

    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t sb_q[$];
    ev_t fp_q[$];

    // RAM responder: word contents are a fixed function of the address being read.
    function automatic logic [63:0] ram_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
        return {a, ~a};
    endfunction
    assign ram_rdata = ram_word(o_ram_araddr);

    axi4_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_m1_bdone(o_m1_bdone),
        .o_ram_araddr(o_ram_araddr), .o_ram_arvalid(o_ram_arvalid),
        .i_ram_arready(ram_arready), .i_ram_rdata(ram_rdata),
        .o_ram_awaddr(o_ram_awaddr), .o_ram_awvalid(o_ram_awvalid),
        .i_ram_awready(ram_awready),
        .o_ram_wdata(o_ram_wdata), .o_ram_wstrb(o_ram_wstrb), .o_ram_wvalid(o_ram_wvalid),
        .i_ram_wready(ram_wready), .i_ram_bvalid(ram_bvalid)
    );

    axi4_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(fp_m0_req), .i_m0_addr(m0_addr),
        .o_m0_gnt(fp_m0_gnt), .o_m0_rvalid(fp_m0_rvalid), .o_m0_rdata(fp_m0_rdata),
        .i_m1_req(fp_m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
        .o_m1_gnt(fp_m1_gnt), .o_m1_rvalid(fp_m1_rvalid), .o_m1_rdata(fp_m1_rdata),
        .o_m1_bdone(fp_m1_bdone),
        .o_ram_araddr(fp_araddr), .o_ram_arvalid(fp_arvalid),
        .i_ram_arready(ram_arready), .i_ram_rdata(ram_rdata),
        .o_ram_awaddr(fp_awaddr), .o_ram_awvalid(fp_awvalid),
        .i_ram_awready(ram_awready),
        .o_ram_wdata(fp_wdata), .o_ram_wstrb(fp_wstrb), .o_ram_wvalid(fp_wvalid),
        .i_ram_wready(ram_wready), .i_ram_bvalid(ram_bvalid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic push(input int k, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic mon_pop(input int k, input logic [63:0] d);
        ev_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got event %0d data %0h, required no event", k, d);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != k || e.data !== d) begin
                n_fail++;
                $display("FAIL sb_event: got event %0d data %0h, required event %0d data %0h",
                         k, d, e.kind, e.data);
            end else begin
                $display("[TB] sb event %0d data %0h", k, d);
            end
        end
    endtask

    task automatic fp_pop(input int k);
        ev_t e;
        n_tests++;
        if (fp_q.size() == 0) begin
            n_fail++;
            $display("FAIL fp_unexpected: got grant event %0d, required none", k);
        end else begin
            e = fp_q.pop_front();
            if (e.kind != k) begin
                n_fail++;
                $display("FAIL fp_grant: got event %0d, required %0d", k, e.kind);
            end else begin
                $display("[TB] fp grant event %0d", k);
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_m0_gnt)    mon_pop(EV_G0, 64'd0);
        if (o_m1_gnt)    mon_pop(EV_G1, 64'd0);
        if (o_m0_rvalid) mon_pop(EV_R0, o_m0_rdata);
        if (o_m1_rvalid) mon_pop(EV_R1, o_m1_rdata);
        if (o_m1_bdone)  mon_pop(EV_B1, 64'd0);
        if (fp_m0_gnt)   fp_pop(EV_G0);
        if (fp_m1_gnt)   fp_pop(EV_G1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig(input int w);
        case (w)
            0:       return o_m0_gnt;
            1:       return o_m1_gnt;
            2:       return o_m0_rvalid;
            3:       return o_m1_rvalid;
            default: return o_m1_bdone;
        endcase
    endfunction

    // Bounded wait on a DUT pulse; returns sitting on the negedge that showed it.
    task automatic wait_ev(input int w, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = sig(w);
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int n;
        int fp_m0_cnt;
        bit bad_gnt;
        bit bad_rv;

        rst_n = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0;
        fp_m0_req = 1'b0; fp_m1_req = 1'b0;
        m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        ram_arready = 1'b0; ram_awready = 1'b0; ram_wready = 1'b0; ram_bvalid = 1'b0;

        // Reset state, with both requests raised to show no grant escapes.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_gnt", o_m0_gnt, 0);
        chk("rst_m1_gnt", o_m1_gnt, 0);
        chk("rst_arvalid", o_ram_arvalid, 0);
        chk("rst_awvalid", o_ram_awvalid, 0);
        chk("rst_wvalid", o_ram_wvalid, 0);
        chk("rst_rvalid", {o_m0_rvalid, o_m1_rvalid}, 0);
        chk("rst_bdone", o_m1_bdone, 0);
        chk("rst_araddr", o_ram_araddr, 0);
        chk("rst_wdata", o_ram_wdata, 0);
        chk("rst_wstrb", o_ram_wstrb, 0);
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) step();

        // Test 4: fixed priority instance, both held -> m1 every time.
        ram_arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ev_t e;
            e.kind = EV_G1;
            e.data = 64'd0;
            fp_q.push_back(e);
        end
        fp_m0_req = 1'b1; fp_m1_req = 1'b1;
        n = 0; fp_m0_cnt = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (fp_m0_gnt || fp_m1_gnt) n++;
            if (fp_m0_gnt) fp_m0_cnt++;
        end
        chk("t4_grant_count", n, 3);
        step();
        fp_m0_req = 1'b0; fp_m1_req = 1'b0;
        chk("t4_m0_never", fp_m0_cnt, 0);
        repeat (4) step();

        // Test 1: single fetch read, immediate arready.
        m0_req = 1'b1; m0_addr = 32'h8000_0000;
        push(EV_G0, 64'd0);
        push(EV_R0, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk("t1_m0_gnt_T", o_m0_gnt, 1);
        chk("t1_m1_gnt_T", o_m1_gnt, 0);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        chk("t1_arvalid_T1", o_ram_arvalid, 1);
        chk("t1_araddr_T1", o_ram_araddr, 32'h8000_0000);
        chk("t1_rvalid_T1", o_m0_rvalid, 0);
        step();
        @(negedge clk);
        chk("t1_m0_rvalid_T2", o_m0_rvalid, 1);
        chk("t1_m0_rdata_T2", o_m0_rdata, 64'h1122_3344_5566_7788);
        chk("t1_m1_quiet_T2", {o_m1_gnt, o_m1_rvalid, o_m1_bdone}, 0);
        step();

        // Test 2: m1 write, awready three cycles late, wready immediate.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0010;
        m1_wdata = 64'hDEAD_BEEF_CAFE_F00D; m1_wstrb = 8'h0F;
        ram_awready = 1'b0; ram_wready = 1'b1;
        push(EV_G1, 64'd0);
        push(EV_B1, 64'd0);
        @(negedge clk);
        chk("t2_m1_gnt", o_m1_gnt, 1);
        step();
        m1_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("t2_awvalid_c%0d", k), o_ram_awvalid, 1);
            chk($sformatf("t2_wvalid_c%0d", k), o_ram_wvalid, (k == 1) ? 1 : 0);
            if (k == 1) begin
                chk("t2_awaddr", o_ram_awaddr, 32'h8000_0010);
                chk("t2_wdata", o_ram_wdata, 64'hDEAD_BEEF_CAFE_F00D);
                chk("t2_wstrb", o_ram_wstrb, 8'h0F);
            end
            step();
            if (k == 3) ram_awready = 1'b1;
        end
        ram_awready = 1'b0;
        @(negedge clk);
        chk("t2_awvalid_dropped", o_ram_awvalid, 0);
        chk("t2_no_bdone_before_bvalid", o_m1_bdone, 0);
        step();
        ram_bvalid = 1'b1;
        @(negedge clk);
        chk("t2_bdone", o_m1_bdone, 1);
        step();
        ram_bvalid = 1'b0;
        m1_we = 1'b0;
        step();

        // Test 5: m1 read stalled 10 cycles with m0 waiting; nothing may move.
        ram_arready = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h8000_0040;
        push(EV_G1, 64'd0);
        push(EV_R1, 64'h8000_0040_7FFF_FFBF);
        push(EV_G0, 64'd0);
        push(EV_R0, 64'h8000_0100_7FFF_FEFF);
        @(negedge clk);
        chk("t5_m1_gnt", o_m1_gnt, 1);
        step();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h8000_0100;
        bad_gnt = 1'b0; bad_rv = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("t5_arvalid_c%0d", k), o_ram_arvalid, 1);
            chk($sformatf("t5_araddr_c%0d", k), o_ram_araddr, 32'h8000_0040);
            if (o_m0_gnt || o_m1_gnt) bad_gnt = 1'b1;
            if (o_m0_rvalid || o_m1_rvalid) bad_rv = 1'b1;
            step();
        end
        chk("t5_no_gnt_while_busy", bad_gnt, 0);
        chk("t5_no_rvalid_while_stalled", bad_rv, 0);
        ram_arready = 1'b1;
        wait_ev(3, "t5_m1_rvalid_seen");
        wait_ev(0, "t5_m0_gnt_seen");
        step();
        m0_req = 1'b0;
        wait_ev(2, "t5_m0_rvalid_seen");
        chk("t5_m1_rdata_held", o_m1_rdata, 64'h8000_0040_7FFF_FFBF);
        step();

        // Test 3: round-robin, both reading, four transactions.
        m0_req = 1'b1; m0_addr = 32'h8000_0200;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0300;
        for (int i = 0; i < 2; i++) begin
            push(EV_G1, 64'd0);
            push(EV_R1, 64'h8000_0300_7FFF_FCFF);
            push(EV_G0, 64'd0);
            push(EV_R0, 64'h8000_0200_7FFF_FDFF);
        end
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (o_m0_gnt || o_m1_gnt) n++;
        end
        chk("t3_grant_count", n, 4);
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        wait_ev(2, "t3_last_rvalid_seen");
        step();

        // Test 6: reset while waiting for the write response.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0050;
        m1_wdata = 64'h0123_4567_89AB_CDEF; m1_wstrb = 8'hFF;
        ram_awready = 1'b1; ram_wready = 1'b1; ram_bvalid = 1'b0;
        push(EV_G1, 64'd0);
        @(negedge clk);
        chk("t6_m1_gnt", o_m1_gnt, 1);
        step();
        m1_req = 1'b0;
        @(negedge clk);
        chk("t6_aw_w_valid", {o_ram_awvalid, o_ram_wvalid}, 2'b11);
        step();
        @(negedge clk);
        chk("t6_in_wr_resp", {o_ram_awvalid, o_ram_wvalid, o_m1_bdone}, 0);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valids", {o_ram_arvalid, o_ram_awvalid, o_ram_wvalid}, 0);
        chk("t6_rst_pulses", {o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m1_bdone}, 0);
        chk("t6_rst_awaddr", o_ram_awaddr, 0);
        chk("t6_rst_wdata", o_ram_wdata, 0);
        chk("t6_rst_wstrb", o_ram_wstrb, 0);
        step();
        step();
        rst_n = 1'b1;
        m1_we = 1'b0;
        step();
        ram_bvalid = 1'b1;
        @(negedge clk);
        chk("t6_late_bvalid_ignored", o_m1_bdone, 0);
        step();
        ram_bvalid = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h8000_0000;
        push(EV_G0, 64'd0);
        push(EV_R0, 64'h1122_3344_5566_7788);
        wait_ev(0, "t6_m0_gnt_after_reset");
        step();
        m0_req = 1'b0;
        wait_ev(2, "t6_m0_rvalid_after_reset");
        repeat (3) step();

        chk("sb_drained", sb_q.size(), 0);
        chk("fp_drained", fp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
